tile_layer_fetcher: RTL and testbench

- Parametrised successor to the fixed 32x32, 8-row tilemap fetch chain. Walks one scanline of a scrollable tile layer and streams 4-pixel groups to the pixel doubler / shift aligner stage over a valid/ready handshake.
- Generalises map size, line length and palette width. Adds per-line X/Y scroll, fine-scroll offset, wrap-around and per-tile X-flip, none of which the fixed chain has.
- Sits in the clk_draw domain, between line/frame CDC and the line-buffer write path.

---
 rtl/tile_layer_fetcher_if.sv | 35 +++
 rtl/tile_layer_fetcher.sv | 157 +++++++++++++++
 tb/tb_tile_layer_fetcher.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_layer_fetcher_if.sv
// Fetcher bus bundle: tilemap read port, tile bitmap read port and the
// 4-pixel group stream toward the pixel doubler / shift aligner.
interface tile_layer_fetcher_if #(
  parameter int unsigned CORDW      = 11,
  parameter int unsigned MAP_W_LOG2 = 5,
  parameter int unsigned MAP_H_LOG2 = 5,
  parameter int unsigned PAL_W      = 5
);
  localparam int unsigned MAP_AW = MAP_H_LOG2 + MAP_W_LOG2;
  localparam int unsigned PIX_W  = 4 * (PAL_W + 4);

  logic              map_re;
  logic [MAP_AW-1:0] map_addr;
  logic [15:0]       map_data;
  logic              tile_re;
  logic [13:0]       tile_addr;
  logic [15:0]       tile_data;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_pixels;
  logic [CORDW-1:0]  out_lb_x;
  logic              out_last;

  modport master (
    output map_re, map_addr, input map_data,
    output tile_re, tile_addr, input tile_data,
    output out_valid, out_pixels, out_lb_x, out_last, input out_ready
  );

  modport slave (
    input map_re, map_addr, output map_data,
    input tile_re, tile_addr, output tile_data,
    input out_valid, out_pixels, out_lb_x, out_last, output out_ready
  );
endinterface

// File: rtl/tile_layer_fetcher.sv
// Walks one scanline of a scrollable, wrapping tile layer and streams
// 4-pixel {palette, pixel} groups to the line-buffer write path.
module tile_layer_fetcher #(
  parameter int unsigned CORDW       = 11,
  parameter int unsigned MAP_W_LOG2  = 5,
  parameter int unsigned MAP_H_LOG2  = 5,
  parameter int unsigned PAL_W       = 5,
  parameter int unsigned LINE_PIXELS = 320
) (
  input  logic                  clk_draw,
  input  logic                  rst_draw_n,
  input  logic                  line_start,
  input  logic [CORDW-1:0]      line_y,
  input  logic [CORDW-1:0]      scroll_x,
  input  logic [CORDW-1:0]      scroll_y,
  output logic                  busy,
  tile_layer_fetcher_if.master  bus
);
  localparam int unsigned SXW_W  = MAP_W_LOG2 + 1;  // source x counted in 4-pixel words
  localparam int unsigned SY_W   = MAP_H_LOG2 + 3;
  localparam int unsigned MAP_AW = MAP_H_LOG2 + MAP_W_LOG2;
  localparam int unsigned ENT_W  = PAL_W + 4;
  localparam int unsigned PIX_W  = 4 * ENT_W;
  localparam int unsigned GROUPS = LINE_PIXELS / 4;

  typedef enum logic [2:0] {IDLE, MAP, TILE, CAP, OUT} state_t;

  state_t             state_q, state_d;
  logic [CORDW-1:0]   g_q, g_d;
  logic [CORDW-1:0]   last_g_q, last_g_d;
  logic [1:0]         fine_q, fine_d;
  logic [SXW_W-1:0]   sxa_q, sxa_d;
  logic [SY_W-1:0]    sy_q, sy_d;
  logic [9:0]         ent_idx_q, ent_idx_d;
  logic [PAL_W-1:0]   ent_pal_q, ent_pal_d;
  logic               ent_flip_q, ent_flip_d;
  logic               fresh_q;
  logic [SXW_W-1:0]   src_q, src_d;
  logic [MAP_AW-1:0]  map_addr_d;
  logic [PIX_W-1:0]   pix_d;
  logic [CORDW-1:0]   lb_d;
  logic [9:0]         idx_sel;
  logic               flip_sel;
  logic [ENT_W-1:0]   e0, e1, e2, e3;

  assign src_q = sxa_q + SXW_W'(g_q);
  assign e0 = {ent_pal_q, bus.tile_data[3:0]};
  assign e1 = {ent_pal_q, bus.tile_data[7:4]};
  assign e2 = {ent_pal_q, bus.tile_data[11:8]};
  assign e3 = {ent_pal_q, bus.tile_data[15:12]};

  // Next-state and line/group bookkeeping
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_g_d   = last_g_q;
    fine_d     = fine_q;
    sxa_d      = sxa_q;
    sy_d       = sy_q;
    ent_idx_d  = ent_idx_q;
    ent_pal_d  = ent_pal_q;
    ent_flip_d = ent_flip_q;
    pix_d      = bus.out_pixels;
    lb_d       = bus.out_lb_x;

    unique case (state_q)
      IDLE: ;
      MAP:  state_d = TILE;
      TILE: begin
        if (fresh_q) begin
          ent_idx_d  = bus.map_data[9:0];
          ent_pal_d  = bus.map_data[10 +: PAL_W];
          ent_flip_d = bus.map_data[15];
        end
        state_d = CAP;
      end
      CAP: begin
        pix_d   = ent_flip_q ? {e3, e2, e1, e0} : {e0, e1, e2, e3};
        lb_d    = {g_q[CORDW-3:0], 2'b00} - CORDW'(fine_q);
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (g_q == last_g_q) begin
            state_d = IDLE;
          end else begin
            g_d = g_q + CORDW'(1);
            // word 0 -> word 1 of the same tile reuses the latched map entry
            state_d = src_q[0] ? MAP : TILE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (line_start) begin
      fine_d   = scroll_x[1:0];
      sxa_d    = SXW_W'(scroll_x >> 2);
      sy_d     = SY_W'(line_y + scroll_y);
      g_d      = '0;
      last_g_d = CORDW'(GROUPS - 1) + CORDW'(scroll_x[1:0] != 2'b00);
      state_d  = MAP;
    end

    src_d      = sxa_d + SXW_W'(g_d);
    map_addr_d = {sy_d[SY_W-1:3], src_d[SXW_W-1:1]};
  end

  // Tile address follows map_data directly on a fresh entry, the latch otherwise
  always_comb begin
    idx_sel  = fresh_q ? bus.map_data[9:0] : ent_idx_q;
    flip_sel = fresh_q ? bus.map_data[15]  : ent_flip_q;
    bus.tile_addr = (state_q == TILE) ? {idx_sel, sy_q[2:0], src_q[0] ^ flip_sel} : 14'd0;
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q        <= IDLE;
      g_q            <= '0;
      last_g_q       <= '0;
      fine_q         <= '0;
      sxa_q          <= '0;
      sy_q           <= '0;
      ent_idx_q      <= '0;
      ent_pal_q      <= '0;
      ent_flip_q     <= 1'b0;
      fresh_q        <= 1'b0;
      busy           <= 1'b0;
      bus.map_re     <= 1'b0;
      bus.map_addr   <= '0;
      bus.tile_re    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_pixels <= '0;
      bus.out_lb_x   <= '0;
    end else begin
      state_q        <= state_d;
      g_q            <= g_d;
      last_g_q       <= last_g_d;
      fine_q         <= fine_d;
      sxa_q          <= sxa_d;
      sy_q           <= sy_d;
      ent_idx_q      <= ent_idx_d;
      ent_pal_q      <= ent_pal_d;
      ent_flip_q     <= ent_flip_d;
      fresh_q        <= (state_q == MAP);
      busy           <= (state_d != IDLE);
      bus.map_re     <= (state_d == MAP);
      bus.map_addr   <= (state_d == MAP) ? map_addr_d : '0;
      bus.tile_re    <= (state_d == TILE);
      bus.out_valid  <= (state_d == OUT);
      bus.out_last   <= (state_d == OUT) && (g_d == last_g_d);
      bus.out_pixels <= pix_d;
      bus.out_lb_x   <= lb_d;
    end
  end
endmodule

// File: tb/tb_tile_layer_fetcher.sv
// Directed bench for tile_layer_fetcher: memory models for map/tile reads
// and a spec-derived model of the expected group stream per line.
module tb_tile_layer_fetcher;
  localparam int unsigned CORDW       = 11;
  localparam int unsigned MAP_W_LOG2  = 5;
  localparam int unsigned MAP_H_LOG2  = 5;
  localparam int unsigned PAL_W       = 5;
  localparam int unsigned LINE_PIXELS = 320;
  localparam int unsigned PIX_W       = 4 * (PAL_W + 4);

  logic             clk_draw = 1'b0;
  logic             rst_draw_n;
  logic             line_start;
  logic [CORDW-1:0] line_y, scroll_x, scroll_y;
  logic             busy;

  tile_layer_fetcher_if #(.CORDW(CORDW), .MAP_W_LOG2(MAP_W_LOG2),
                          .MAP_H_LOG2(MAP_H_LOG2), .PAL_W(PAL_W)) bus ();

  tile_layer_fetcher #(.CORDW(CORDW), .MAP_W_LOG2(MAP_W_LOG2), .MAP_H_LOG2(MAP_H_LOG2),
                       .PAL_W(PAL_W), .LINE_PIXELS(LINE_PIXELS)) dut (
    .clk_draw  (clk_draw),
    .rst_draw_n(rst_draw_n),
    .line_start(line_start),
    .line_y    (line_y),
    .scroll_x  (scroll_x),
    .scroll_y  (scroll_y),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk_draw = ~clk_draw;

  int errors = 0;
  int checks = 0;
  bit flip_all = 1'b0;
  bit tile_const = 1'b0;

  logic [PIX_W-1:0] exp_pix[$];
  logic [CORDW-1:0] exp_lb[$];
  int               exp_maps;
  logic [PIX_W-1:0] obs_pix[$];
  logic [CORDW-1:0] obs_lb[$];
  bit               obs_last[$];
  logic [9:0]       map_addrs[$];
  logic [13:0]      tile_addrs[$];
  int               n_map_re, both_high, unstable, lat_map, lat_valid;
  bit               timed_out;

  function automatic logic [15:0] map_fn(input logic [9:0] a);
    return {flip_all, 5'(a * 3 + 7), a};
  endfunction

  function automatic logic [15:0] tile_fn(input logic [13:0] t);
    return tile_const ? 16'h4321 : ({t, 2'b01} ^ 16'hA5C3);
  endfunction

  // Registered-read memories: data valid the cycle after the strobe
  always @(posedge clk_draw) begin
    if (bus.map_re)  bus.map_data  <= map_fn(bus.map_addr);
    if (bus.tile_re) bus.tile_data <= tile_fn(bus.tile_addr);
  end

  task automatic build_model(input logic [CORDW-1:0] sx, input logic [CORDW-1:0] sy,
                             input logic [CORDW-1:0] ly);
    int n, fine;
    bit prev_wc;
    logic [7:0] sxa, src, syv;
    logic [15:0] ent, td;
    logic [4:0] pal;
    bit fl, wc;
    exp_pix.delete(); exp_lb.delete(); exp_maps = 0;
    fine = int'(sx[1:0]);
    sxa  = 8'(sx) & 8'hFC;
    syv  = 8'(ly + sy);
    n    = (fine != 0) ? 81 : 80;
    prev_wc = 1'b1;
    for (int g = 0; g < n; g++) begin
      src = 8'(sxa + 8'(4 * g));
      wc  = src[2];
      if (g == 0 || prev_wc) exp_maps++;
      prev_wc = wc;
      ent = map_fn({syv[7:3], src[7:3]});
      pal = ent[14:10];
      fl  = ent[15];
      td  = tile_fn({ent[9:0], syv[2:0], wc ^ fl});
      exp_pix.push_back(fl ? {pal, td[15:12], pal, td[11:8], pal, td[7:4], pal, td[3:0]}
                           : {pal, td[3:0], pal, td[7:4], pal, td[11:8], pal, td[15:12]});
      exp_lb.push_back(11'(4 * g - fine));
    end
  endtask

  // Starts a line and records everything the DUT emits until busy drops
  task automatic run_line(input logic [CORDW-1:0] sx, input logic [CORDW-1:0] sy,
                          input logic [CORDW-1:0] ly, input bit rnd_ready, input int stop_after);
    bit prev_stall, done;
    logic [PIX_W-1:0] prev_pix;
    logic [CORDW-1:0] prev_lb;
    obs_pix.delete(); obs_lb.delete(); obs_last.delete();
    map_addrs.delete(); tile_addrs.delete();
    n_map_re = 0; both_high = 0; unstable = 0; lat_map = -1; lat_valid = -1;
    prev_stall = 1'b0; done = 1'b0; prev_pix = '0; prev_lb = '0;
    @(negedge clk_draw);
    scroll_x = sx; scroll_y = sy; line_y = ly; line_start = 1'b1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk_draw);
      line_start = 1'b0;
      if (stop_after > 0 && obs_pix.size() == stop_after) begin
        bus.out_ready = 1'b0;
        done = 1'b1;
        break;
      end
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.map_re) begin
        n_map_re++;
        map_addrs.push_back(bus.map_addr);
        if (lat_map < 0) lat_map = cyc;
      end
      if (bus.tile_re) tile_addrs.push_back(bus.tile_addr);
      if (bus.map_re && bus.tile_re) both_high++;
      if (bus.out_valid && lat_valid < 0) lat_valid = cyc;
      if (prev_stall && (!bus.out_valid || bus.out_pixels !== prev_pix || bus.out_lb_x !== prev_lb))
        unstable++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pixels;
      prev_lb    = bus.out_lb_x;
      if (bus.out_valid && bus.out_ready) begin
        obs_pix.push_back(bus.out_pixels);
        obs_lb.push_back(bus.out_lb_x);
        obs_last.push_back(bus.out_last);
      end
      if (!busy && cyc > 1) begin
        done = 1'b1;
        break;
      end
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    int waited;
    checks++;
    if ({busy, bus.out_valid, bus.map_re, bus.tile_re, bus.out_last} !== 5'b0) begin
      errors++; $display("FAIL reset_idle: got %b required 00000",
                         {busy, bus.out_valid, bus.map_re, bus.tile_re, bus.out_last});
    end
    checks++;
    if (bus.out_pixels !== '0 || bus.out_lb_x !== '0 || bus.map_addr !== '0) begin
      errors++; $display("FAIL reset_data: pix %0h lb %0d maddr %0h required 0",
                         bus.out_pixels, bus.out_lb_x, bus.map_addr);
    end
    @(negedge clk_draw);
    scroll_x = 11'd1; scroll_y = '0; line_y = '0; line_start = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk_draw);
    line_start = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 10) begin
      @(negedge clk_draw); waited++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lb_x !== 11'd2047) begin
      errors++; $display("FAIL reset_pre_out: valid %b lb %0d required 1 2047",
                         bus.out_valid, bus.out_lb_x);
    end
    #2 rst_draw_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, busy, bus.map_re, bus.tile_re} !== 4'b0 || bus.out_lb_x !== '0 ||
        bus.out_pixels !== '0 || bus.tile_addr !== '0) begin
      errors++; $display("FAIL reset_async: valid %b busy %b mre %b tre %b lb %0d required zeros",
                         bus.out_valid, busy, bus.map_re, bus.tile_re, bus.out_lb_x);
    end
    @(negedge clk_draw);
    rst_draw_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk_draw);
    checks++;
    if ({busy, bus.out_valid, bus.map_re, bus.tile_re} !== 4'b0) begin
      errors++; $display("FAIL reset_release_idle: got %b required 0000",
                         {busy, bus.out_valid, bus.map_re, bus.tile_re});
    end
  endtask

  task automatic test_plain_line();
    int n_last;
    build_model(11'd0, 11'd0, 11'd9);
    run_line(11'd0, 11'd0, 11'd9, 1'b0, 0);
    checks++;
    if (timed_out || obs_pix.size() != 80) begin
      errors++; $display("FAIL plain_groups: got %0d (timeout %b) required 80", obs_pix.size(), timed_out);
    end
    checks++;
    if (lat_map != 1 || lat_valid != 4) begin
      errors++; $display("FAIL plain_latency: map_re %0d valid %0d required 1 4", lat_map, lat_valid);
    end
    checks++;
    if (map_addrs.size() == 0 || map_addrs[0] !== 10'd32) begin
      errors++; $display("FAIL plain_first_map_addr: got %0d required 32",
                         map_addrs.size() ? map_addrs[0] : 10'h3FF);
    end
    checks++;
    if (tile_addrs.size() == 0 || tile_addrs[0][3:1] !== 3'd1) begin
      errors++; $display("FAIL plain_tile_row: got %0d required 1",
                         tile_addrs.size() ? tile_addrs[0][3:1] : 3'd7);
    end
    checks++;
    if (n_map_re != 40 || both_high != 0) begin
      errors++; $display("FAIL plain_map_reads: got %0d both %0d required 40 0", n_map_re, both_high);
    end
    n_last = 0;
    foreach (obs_last[i]) if (obs_last[i]) n_last++;
    checks++;
    if (n_last != 1 || obs_last.size() == 0 || !obs_last[obs_last.size()-1] ||
        obs_lb[obs_lb.size()-1] !== 11'd316) begin
      errors++; $display("FAIL plain_last: count %0d required 1 on lb 316", n_last);
    end
    for (int i = 0; i < obs_lb.size() && i < 80; i++) begin
      checks++;
      if (obs_lb[i] !== 11'(4 * i) || obs_pix[i] !== exp_pix[i]) begin
        errors++; $display("FAIL plain_group%0d: lb %0d pix %0h required %0d %0h",
                           i, obs_lb[i], obs_pix[i], 4 * i, exp_pix[i]);
      end
    end
  endtask

  task automatic test_fine_flip();
    logic [PIX_W-1:0] want;
    flip_all = 1'b1; tile_const = 1'b1;
    want = {5'd7, 4'h4, 5'd7, 4'h3, 5'd7, 4'h2, 5'd7, 4'h1};
    build_model(11'd6, 11'd0, 11'd0);
    run_line(11'd6, 11'd0, 11'd0, 1'b0, 0);
    checks++;
    if (timed_out || obs_pix.size() != 81) begin
      errors++; $display("FAIL flip_groups: got %0d required 81", obs_pix.size());
    end
    checks++;
    if (obs_pix.size() == 0 || obs_lb[0] !== 11'd2046 || obs_pix[0] !== want) begin
      errors++; $display("FAIL flip_first: lb %0d pix %0h required 2046 %0h",
                         obs_lb.size() ? obs_lb[0] : 11'd0, obs_pix.size() ? obs_pix[0] : '0, want);
    end
    checks++;
    if (tile_addrs.size() == 0 || tile_addrs[0][0] !== 1'b0) begin
      errors++; $display("FAIL flip_word: got %b required 0", tile_addrs.size() ? tile_addrs[0][0] : 1'b1);
    end
    checks++;
    if (n_map_re != 41 || n_map_re != exp_maps) begin
      errors++; $display("FAIL flip_map_reads: got %0d required 41", n_map_re);
    end
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i] || obs_lb[i] !== exp_lb[i]) begin
        errors++; $display("FAIL flip_group%0d: pix %0h lb %0d required %0h %0d",
                           i, obs_pix[i], obs_lb[i], exp_pix[i], exp_lb[i]);
      end
    end
    flip_all = 1'b0; tile_const = 1'b0;
  endtask

  task automatic test_wrap();
    build_model(11'd252, 11'd10, 11'd250);
    run_line(11'd252, 11'd10, 11'd250, 1'b0, 0);
    checks++;
    if (map_addrs.size() < 2 || map_addrs[0] !== 10'd31 || map_addrs[1] !== 10'd0) begin
      errors++; $display("FAIL wrap_map_addr: got %0d %0d required 31 0",
                         map_addrs.size() > 0 ? map_addrs[0] : 10'h3FF,
                         map_addrs.size() > 1 ? map_addrs[1] : 10'h3FF);
    end
    checks++;
    if (tile_addrs.size() == 0 || tile_addrs[0][3:1] !== 3'd4) begin
      errors++; $display("FAIL wrap_row: got %0d required 4",
                         tile_addrs.size() ? tile_addrs[0][3:1] : 3'd7);
    end
    checks++;
    if (timed_out || obs_pix.size() != 80) begin
      errors++; $display("FAIL wrap_groups: got %0d required 80", obs_pix.size());
    end
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i] || obs_lb[i] !== exp_lb[i]) begin
        errors++; $display("FAIL wrap_group%0d: pix %0h lb %0d required %0h %0d",
                           i, obs_pix[i], obs_lb[i], exp_pix[i], exp_lb[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    build_model(11'd3, 11'd5, 11'd100);
    run_line(11'd3, 11'd5, 11'd100, 1'b1, 0);
    checks++;
    if (timed_out || obs_pix.size() != 81) begin
      errors++; $display("FAIL bp_groups: got %0d (timeout %b) required 81", obs_pix.size(), timed_out);
    end
    checks++;
    if (unstable != 0 || both_high != 0) begin
      errors++; $display("FAIL bp_stable: unstable %0d both %0d required 0 0", unstable, both_high);
    end
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i] || obs_lb[i] !== exp_lb[i]) begin
        errors++; $display("FAIL bp_group%0d: pix %0h lb %0d required %0h %0d",
                           i, obs_pix[i], obs_lb[i], exp_pix[i], exp_lb[i]);
      end
    end
  endtask

  task automatic test_restart();
    int waited;
    run_line(11'd8, 11'd0, 11'd20, 1'b0, 37);
    waited = 0;
    while (!bus.out_valid && waited < 8) begin
      @(negedge clk_draw); waited++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lb_x !== 11'd148) begin
      errors++; $display("FAIL restart_g37: valid %b lb %0d required 1 148", bus.out_valid, bus.out_lb_x);
    end
    build_model(11'd0, 11'd0, 11'd40);
    scroll_x = 11'd0; scroll_y = 11'd0; line_y = 11'd40;
    line_start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk_draw);
    line_start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.map_re !== 1'b1 || bus.map_addr !== 10'd160 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_plus1: valid %b mre %b maddr %0d busy %b required 0 1 160 1",
                         bus.out_valid, bus.map_re, bus.map_addr, busy);
    end
    @(negedge clk_draw);
    checks++;
    if (bus.tile_re !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL restart_plus2: tre %b valid %b required 1 0", bus.tile_re, bus.out_valid);
    end
    repeat (2) @(negedge clk_draw);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lb_x !== 11'd0 || bus.out_pixels !== exp_pix[0]) begin
      errors++; $display("FAIL restart_plus4: valid %b lb %0d pix %0h required 1 0 %0h",
                         bus.out_valid, bus.out_lb_x, bus.out_pixels, exp_pix[0]);
    end
    waited = 0;
    while (busy && waited < 1000) begin
      @(negedge clk_draw); waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL restart_drain: busy %b required 0", busy);
    end
  endtask

  initial begin
    rst_draw_n = 1'b0; line_start = 1'b0; line_y = '0; scroll_x = '0; scroll_y = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk_draw);
    rst_draw_n = 1'b1;
    @(negedge clk_draw);
    test_reset();
    test_plain_line();
    test_fine_flip();
    test_wrap();
    test_backpressure();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
